// File: rtl/fsm_seqdet_p.sv
// Programmable Moore sequence detector over a serial bit stream with
// overlap/non-overlap matching, a valid qualifier and a saturating match counter.
module fsm_seqdet_p #(
  parameter int                 PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1011,
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               x_vld,
  input  logic               ovl,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               pat_load,
  output logic               z,
  output logic [3:0]         current_state,
  output logic [3:0]         state_reg,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [3:0]         nxt_state;
  int                 cap;

  // True when the newest k bits of h equal the first k bits of p (p MSB first).
  function automatic logic prefix_match(input logic [PAT_LEN-1:0] h,
                                        input logic [PAT_LEN-1:0] p,
                                        input int                 k);
    logic [PAT_LEN-1:0] mask;
    mask = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
    return ((h ^ (p >> (PAT_LEN - k))) & mask) == '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Longest pattern prefix that is a suffix of the updated history, bounded by
  // cap so that bits older than the current partial match are never credited.
  always_comb begin
    hist_nxt = (hist << 1) | PAT_LEN'(x);
    if (int'(current_state) == PAT_LEN && !ovl)
      cap = 1;
    else
      cap = int'(current_state) + 1;
    if (cap > PAT_LEN)
      cap = PAT_LEN;
    nxt_state = '0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= cap && prefix_match(hist_nxt, pat, k))
        nxt_state = 4'(k);
    end
  end

  assign state_reg = x_vld ? nxt_state : current_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      current_state <= '0;
      hist          <= '0;
      pat           <= PAT_RESET;
      match_cnt     <= '0;
      z             <= 1'b0;
    end else if (pat_load) begin
      current_state <= '0;
      hist          <= '0;
      pat           <= pat_in;
      match_cnt     <= '0;
      z             <= 1'b0;
    end else if (x_vld) begin
      current_state <= nxt_state;
      hist          <= hist_nxt;
      z             <= (int'(nxt_state) == PAT_LEN);
      if (int'(nxt_state) == PAT_LEN)
        match_cnt <= sat_inc(match_cnt);
    end
  end

endmodule

// File: tb/tb_fsm_seqdet_p.sv
// Scoreboard bench for fsm_seqdet_p: stimulus queues post-edge expectations,
// a monitor pops one per clock and compares state, z and match_cnt.
module tb_fsm_seqdet_p;

  logic       clk = 1'b0;
  logic       rst_n, x, x_vld, ovl, pat_load;
  logic [3:0] pat_in;
  logic       z;
  logic [3:0] current_state, state_reg;
  logic [1:0] match_cnt;

  int nchk  = 0;
  int nfail = 0;

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic       zz;
    logic [1:0] cnt;
    logic [3:0] sr;
    logic       chk_sr;
  } exp_t;

  exp_t q[$];

  fsm_seqdet_p #(.PAT_LEN(4), .PAT_RESET(4'b1011), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .x_vld(x_vld), .ovl(ovl),
    .pat_in(pat_in), .pat_load(pat_load), .z(z),
    .current_state(current_state), .state_reg(state_reg), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        nchk++;
        if (current_state !== e.st) begin
          nfail++;
          $display("FAIL %s state got %0d want %0d", e.nm, current_state, e.st);
        end
        nchk++;
        if (z !== e.zz) begin
          nfail++;
          $display("FAIL %s z got %0b want %0b", e.nm, z, e.zz);
        end
        nchk++;
        if (match_cnt !== e.cnt) begin
          nfail++;
          $display("FAIL %s match_cnt got %0d want %0d", e.nm, match_cnt, e.cnt);
        end
        if (e.chk_sr) begin
          nchk++;
          if (state_reg !== e.sr) begin
            nfail++;
            $display("FAIL %s state_reg got %0d want %0d", e.nm, state_reg, e.sr);
          end
        end
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic v, input logic xb,
                      input logic o, input logic pl, input logic [3:0] pi,
                      input logic [3:0] st, input logic zz, input logic [1:0] c,
                      input logic chk_sr = 1'b0, input logic [3:0] sr = 4'd0);
    exp_t e;
    @(negedge clk);
    rst_n = r; x_vld = v; x = xb; ovl = o; pat_load = pl; pat_in = pi;
    e.nm = nm; e.st = st; e.zz = zz; e.cnt = c; e.chk_sr = chk_sr; e.sr = sr;
    q.push_back(e);
  endtask

  task automatic bit_in(input string nm, input logic xb, input logic o,
                        input logic [3:0] st, input logic zz, input logic [1:0] c);
    step(nm, 1'b1, 1'b1, xb, o, 1'b0, 4'd0, st, zz, c);
  endtask

  task automatic gap(input string nm, input logic xb,
                     input logic [3:0] st, input logic zz, input logic [1:0] c);
    step(nm, 1'b1, 1'b0, xb, 1'b1, 1'b0, 4'd0, st, zz, c);
  endtask

  task automatic do_reset(input string nm);
    step(nm, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; x = 1'b1; x_vld = 1'b1; ovl = 1'b1; pat_load = 1'b0; pat_in = '0;

    // Reset with x_vld/x high; state_reg shows next state from state 0 on x=1.
    do_reset("rst0");
    step("rst1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b1, 4'd1);
    bit_in("rpat", 1, 1, 1, 0, 0);
    bit_in("rpat", 0, 1, 2, 0, 0);
    bit_in("rpat", 1, 1, 3, 0, 0);
    bit_in("rpat", 1, 1, 4, 1, 1);

    // Overlapping: 1011011.
    do_reset("ovl_rst");
    bit_in("ovl", 1, 1, 1, 0, 0);
    bit_in("ovl", 0, 1, 2, 0, 0);
    bit_in("ovl", 1, 1, 3, 0, 0);
    bit_in("ovl", 1, 1, 4, 1, 1);
    bit_in("ovl", 0, 1, 2, 0, 1);
    bit_in("ovl", 1, 1, 3, 0, 1);
    bit_in("ovl", 1, 1, 4, 1, 2);

    // Non-overlapping: same stream.
    do_reset("novl_rst");
    bit_in("novl", 1, 0, 1, 0, 0);
    bit_in("novl", 0, 0, 2, 0, 0);
    bit_in("novl", 1, 0, 3, 0, 0);
    bit_in("novl", 1, 0, 4, 1, 1);
    bit_in("novl", 0, 0, 0, 0, 1);
    bit_in("novl", 1, 0, 1, 0, 1);
    bit_in("novl", 1, 0, 1, 0, 1);

    // Valid gaps with x toggling between bits of 1011.
    do_reset("gap_rst");
    bit_in("gap", 1, 1, 1, 0, 0);
    gap("gap", 0, 1, 0, 0); gap("gap", 1, 1, 0, 0); gap("gap", 0, 1, 0, 0);
    bit_in("gap", 0, 1, 2, 0, 0);
    gap("gap", 1, 2, 0, 0); gap("gap", 0, 2, 0, 0); gap("gap", 1, 2, 0, 0);
    bit_in("gap", 1, 1, 3, 0, 0);
    gap("gap", 0, 3, 0, 0); gap("gap", 1, 3, 0, 0); gap("gap", 0, 3, 0, 0);
    bit_in("gap", 1, 1, 4, 1, 1);
    gap("gap", 0, 4, 1, 1); gap("gap", 1, 4, 1, 1); gap("gap", 0, 4, 1, 1);

    // Reach state 3 with match_cnt=1, then load 0000 (x ignored that cycle).
    bit_in("pre_ld", 0, 1, 2, 0, 1);
    bit_in("pre_ld", 1, 1, 3, 0, 1);
    step("load", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 2'd0);
    bit_in("sat", 0, 1, 1, 0, 0);
    bit_in("sat", 0, 1, 2, 0, 0);
    bit_in("sat", 0, 1, 3, 0, 0);
    bit_in("sat", 0, 1, 4, 1, 1);
    bit_in("sat", 0, 1, 4, 1, 2);
    bit_in("sat", 0, 1, 4, 1, 3);
    bit_in("sat", 0, 1, 4, 1, 3);

    // Reset mid-stream restores pattern 1011.
    step("load2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 2'd0);
    bit_in("mid", 0, 1, 1, 0, 0);
    bit_in("mid", 0, 1, 2, 0, 0);
    bit_in("mid", 0, 1, 3, 0, 0);
    step("mid_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 2'd0);
    bit_in("post_rst", 0, 1, 0, 0, 0);
    bit_in("post_rst", 0, 1, 0, 0, 0);
    bit_in("post_rst", 0, 1, 0, 0, 0);
    bit_in("post_rst", 0, 1, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    nchk++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/fsm_seqdet_p.md
# fsm_seqdet_p

Parametrised, programmable Moore sequence detector for a serial bit stream, with selectable overlapping or non-overlapping matching, a qualifying valid strobe and a saturating match counter. It generalises the fixed 4-state detector to pattern lengths from 2 to 15 bits, and it exposes current and next state for waveform debug. It sits directly on a 1-bit serial input and feeds `z` and `match_cnt` to downstream control or status logic.

## Interface
- `PAT_LEN`, 4: pattern length in bits; legal range 2..15.
- `PAT_RESET`, 4'b1011: pattern loaded on reset; width `PAT_LEN`.
- `CNT_W`, 8: width of `match_cnt`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `x`  in  1  serial data bit.
- `x_vld`  in  1  qualifies `x`; a bit is consumed only when this is 1.
- `ovl`  in  1  1 = overlapping match mode, 0 = non-overlapping; sampled with each consumed bit.
- `pat_in`  in  `PAT_LEN`  new pattern value.
- `pat_load`  in  1  loads `pat_in`, which has priority over `x_vld`.
- `z`  out  1  Moore output; 1 while `current_state == PAT_LEN`.
- `current_state`  out  4  registered state, equal to the number of pattern bits currently matched (0..`PAT_LEN`).
- `state_reg`  out  4  combinational next state (debug).
- `match_cnt`  out  `CNT_W`  number of completed matches, saturating.

## Operation
- Pattern bit order: `pat[PAT_LEN-1]` is the first bit expected on the wire.
- State k: the last k consumed bits equal `pat[PAT_LEN-1 -: k]`, with k maximal. The block keeps a `PAT_LEN`-bit history shift register with the newest bit in the LSB.
- Next state on a consumed bit b:
  - Let `cap = state+1`, except `cap = 1` when `state == PAT_LEN` and `ovl == 0`.
  - `next` = the largest k' ≤ min(`cap`, `PAT_LEN`) such that the last k' bits (including b) equal the first k' pattern bits. If no such k' exists, `next = 0`.
  - This is KMP-equivalent and is computed combinationally over the history register.
- When `x_vld = 0`: state, history, `z` and `match_cnt` hold. `state_reg` equals `current_state`.
- Priority, highest first:
  1. `rst_n = 0`: state 0, history 0, pattern ← `PAT_RESET`, `match_cnt` 0.
  2. `pat_load = 1`: pattern ← `pat_in`, state 0, history 0, `match_cnt` 0. `x` is ignored in this cycle.
  3. `x_vld = 1`: normal step.
- `match_cnt` increments by 1 on every step whose next state is `PAT_LEN`, including overlapping re-entry from `PAT_LEN` to `PAT_LEN`. It holds at 2^`CNT_W`−1 and does not wrap.
- `z` is decoded only from the registered state. There is no combinational path from `x` to `z`.

## Timing
- Reset values: `z` 0, `current_state` 0, `match_cnt` 0, pattern `PAT_RESET`. `state_reg` reflects the next state derived from state 0.
- Latency: the last pattern bit, presented with `x_vld` before edge N, makes `z` = 1 after edge N (one cycle).
- `z` stays high only while the state remains `PAT_LEN`:
  - holds through `x_vld` gaps;
  - drops after the next consumed bit unless that bit re-completes a match (overlap mode only).
- `ovl` and `pat_in` are sampled only at the edge where they are used. Changing `ovl` mid-stream affects only the current step.
- Reset mid-operation takes effect at the next edge regardless of `x_vld` or `pat_load`.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles while driving `x_vld` = 1 and `x` = 1 → `z` = 0, `current_state` = 0, `match_cnt` = 0. Then send 1,0,1,1 → `z` rises after the 4th edge, confirming the pattern is 1011.
- Overlap, `PAT_LEN` = 4, `ovl` = 1: send 1,0,1,1,0,1,1 → `current_state` sequence 1,2,3,4,2,3,4; `z` high after bits 4 and 7; `match_cnt` = 2.
- Non-overlap, `ovl` = 0, same stream → states 1,2,3,4,0,1,1; a single `z` pulse; `match_cnt` = 1.
- Valid gaps: insert 3 cycles of `x_vld` = 0 with `x` toggling between every bit of 1011 → states advance only on valid cycles; `z` rises after the 4th valid bit and holds through subsequent gaps.
- Pattern load with saturation, `CNT_W` = 2: load 4'b0000 mid-stream at state 3 → state 0 and `match_cnt` 0 on the next edge. Then send 7 zeros with `ovl` = 1 → `z` high from the 4th bit onward; `match_cnt` reaches 3 and saturates at 3 on the 7th bit.
- Reset mid-stream: after loading 4'b0000 and reaching state 3, drive `rst_n` low for 1 cycle → state 0, pattern reverts to 1011. Then 0,0,0,0 produces no match.
